alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares one instance of the team's 32-bit combinational `alu` between two independent requesters, e.g. the pipeline execute stage and a multi-cycle helper unit.
- Arbitrates round-robin and registers the winning operands into an issue stage.
- Evaluates the ALU on the registered operands and steers the result into a per-port one-entry response buffer with valid/ready backpressure.
- Sits between the requesters and the `alu` instance, which it contains.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- OP_WIDTH, 16, one-hot ALUop width.

Ports (i = 0, 1; one set per port):
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_i_valid  in  1  request valid.
- req_i_ready  out  1  request accepted when valid && ready at a rising edge.
- req_i_a  in  DATA_WIDTH  operand A.
- req_i_b  in  DATA_WIDTH  operand B.
- req_i_op  in  OP_WIDTH  one-hot ALUop, using the team's ALUOP_* encodings (AND, OR, ADD, SUB, SLT, XOR, NOR, SLTU, SLL, SRL, SRA, LUI).
- rsp_i_valid  out  1  response buffer holds a result.
- rsp_i_ready  in  1  consumer takes the result.
- rsp_i_result  out  DATA_WIDTH  ALU result.
- rsp_i_zero  out  1  result == 0.
- rsp_i_overflow  out  1  signed overflow.
- rsp_i_carryout  out  1  adder carry.
- rsp_i_illegal  out  1  op was not a single defined ALUOP code.

## Operation
**Per-port busy**
- busy_i = (issue register valid && issue owner == i) || rsp_i_valid.
- Each port has at most one operation in flight.

**Eligibility and grant**
- eligible_i = req_i_valid && !busy_i.
- Round-robin pointer `last` (1 bit) holds the most recently granted port.
- One port eligible: that port is granted.
- Both ports eligible: the port != last is granted.
- req_i_ready = grant_i. Ready may depend on valid; ready never depends on rsp_i_ready.
- `last` updates only on an accepted handshake.

**Issue register**
- Contents: valid, owner, a, b, op.
- Loaded on acceptance.
- Cleared the next cycle, because its result is always written to the owner's response buffer.

**ALU stage**
- The `alu` is driven from the issue register.
- Illegal op: op is not exactly one of the 12 defined codes, including 0 and multi-hot values. Response is illegal=1, result=0, zero=0, overflow=0, carryout=0.
- Legal op: result comes from the ALU; zero = (result == 0).
- overflow and carryout are forwarded only for ADD, SUB, SLT and SLTU; they are 0 for all other ops.

**Response buffer**
- Written when the issue register is valid for that owner; rsp_i_valid is then set.
- Cleared on rsp_i_valid && rsp_i_ready.
- All rsp_i_* data is held stable while valid && !ready.

**Independence**
- The ports are independent: backpressure on one port never stalls the other.

## Timing
**Reset**
- While resetn is sampled low:
  - issue register invalid
  - both response buffers empty
  - all rsp_i_* outputs 0
  - last = 1, so port 0 wins the first tie
- req_i_ready is forced to 0 combinationally while resetn is low.

**Latency**
- Handshake sampled at the end of cycle n.
- Issue register valid in cycle n+1.
- rsp_i_valid high in cycle n+2.

**Throughput**
- Per port: if rsp_i_ready is high in n+2, the port can be granted again in n+3. Minimum 3 cycles per op per port.
- Both ports together: one acceptance per cycle, alternating when both are eligible.

**Simultaneous events**
- A response-buffer clear and a new request on the same port in the same cycle: the request is not granted until the next cycle.
- An issue write to port i never coincides with a pending rsp_i_valid, because busy_i prevents it.

**Reset mid-operation**
- In-flight and buffered results are discarded; no response is produced for them.
- The pointer returns to last = 1.

**Reset release**
- Requests are accepted from the first cycle in which resetn is sampled high.

## Test plan
- Port 0 ADD, a=0x7FFFFFFF, b=0x00000001, accepted cycle n -> rsp_0_valid in n+2 with result=0x80000000, overflow=1, carryout=0, zero=0.
- Port 1 SUB, a=b=0x12345678 -> result=0, zero=1, overflow=0; then SLT a=0xFFFFFFFF, b=1 -> result=1.
- Both ports valid from reset, continuous requests, rsp_ready=1 -> port 0 granted cycle n, port 1 n+1, port 0 n+3, port 1 n+4; responses at n+2, n+3, n+5, n+6.
- Backpressure: rsp_0_ready=0 for 5 cycles after rsp_0_valid -> rsp_0_* held constant; req_0_ready=0 throughout; port 1 keeps completing an op every 3 cycles.
- Illegal ops: port 0 op=16'h0003, then op=16'h0000, then op=16'h1000 -> each gives rsp_0_illegal=1, result=0, zero=0; a following AND 0xF0F0F0F0 & 0x0FF00FF0 gives result=0x00F000F0, illegal=0.
- Reset mid-flight: assert resetn=0 in the cycle after acceptance -> rsp_0_valid never rises for that op; after release, two simultaneous requests give port 0 the first grant.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one 32-bit combinational ALU between two requesters.
//            Round-robin grant -> one-entry issue register -> ALU ->
//            per-port one-entry response buffer with valid/ready.
// Ports    : clk, resetn (sync, active-low)
//            req_{0,1}_{valid,ready,a,b,op}        request channel per port
//            rsp_{0,1}_{valid,ready,result,zero,
//                       overflow,carryout,illegal} response channel per port
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_0_valid,
    output logic                  req_0_ready,
    input  logic [DATA_WIDTH-1:0] req_0_a,
    input  logic [DATA_WIDTH-1:0] req_0_b,
    input  logic [OP_WIDTH-1:0]   req_0_op,
    input  logic                  req_1_valid,
    output logic                  req_1_ready,
    input  logic [DATA_WIDTH-1:0] req_1_a,
    input  logic [DATA_WIDTH-1:0] req_1_b,
    input  logic [OP_WIDTH-1:0]   req_1_op,
    output logic                  rsp_0_valid,
    input  logic                  rsp_0_ready,
    output logic [DATA_WIDTH-1:0] rsp_0_result,
    output logic                  rsp_0_zero,
    output logic                  rsp_0_overflow,
    output logic                  rsp_0_carryout,
    output logic                  rsp_0_illegal,
    output logic                  rsp_1_valid,
    input  logic                  rsp_1_ready,
    output logic [DATA_WIDTH-1:0] rsp_1_result,
    output logic                  rsp_1_zero,
    output logic                  rsp_1_overflow,
    output logic                  rsp_1_carryout,
    output logic                  rsp_1_illegal
);

    localparam int c_MSB = DATA_WIDTH - 1;
    localparam int c_SHW = $clog2(DATA_WIDTH);

    // One-hot ALUop encodings
    localparam logic [OP_WIDTH-1:0] c_ALUOP_AND  = OP_WIDTH'(16'h0001);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_OR   = OP_WIDTH'(16'h0002);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_ADD  = OP_WIDTH'(16'h0004);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_SUB  = OP_WIDTH'(16'h0008);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_SLT  = OP_WIDTH'(16'h0010);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_XOR  = OP_WIDTH'(16'h0020);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_NOR  = OP_WIDTH'(16'h0040);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_SLTU = OP_WIDTH'(16'h0080);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_SLL  = OP_WIDTH'(16'h0100);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_SRL  = OP_WIDTH'(16'h0200);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_SRA  = OP_WIDTH'(16'h0400);
    localparam logic [OP_WIDTH-1:0] c_ALUOP_LUI  = OP_WIDTH'(16'h0800);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  r_iss_valid;
    logic                  r_iss_owner;
    logic [DATA_WIDTH-1:0] r_iss_a;
    logic [DATA_WIDTH-1:0] r_iss_b;
    logic [OP_WIDTH-1:0]   r_iss_op;
    logic                  r_last;

    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_result [2];
    logic [1:0]            r_rsp_zero;
    logic [1:0]            r_rsp_ovf;
    logic [1:0]            r_rsp_cout;
    logic [1:0]            r_rsp_ill;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0] w_req_valid;
    logic [1:0] w_rsp_ready;
    logic [1:0] w_iss_dst;
    logic [1:0] w_busy;
    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic       w_accept;
    logic       w_sel;

    assign w_req_valid = {req_1_valid, req_0_valid};
    assign w_rsp_ready = {rsp_1_ready, rsp_0_ready};
    assign w_iss_dst   = {r_iss_valid & r_iss_owner, r_iss_valid & ~r_iss_owner};

    // A port is busy from acceptance until its response is consumed, so
    // each port has at most one operation in flight.
    assign w_busy = w_iss_dst | r_rsp_valid;
    assign w_elig = w_req_valid & ~w_busy;

    always_comb begin
        w_grant = 2'b00;
        if (resetn) begin
            case (w_elig)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_accept    = |w_grant;
    assign w_sel       = w_grant[1];
    assign req_0_ready = w_grant[0];
    assign req_1_ready = w_grant[1];

    // ------------------------------------------------------------------
    // Issue register: lives exactly one cycle, its result always lands
    // in the owner's (guaranteed empty) response buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_iss_valid <= 1'b0;
            r_iss_owner <= 1'b0;
            r_iss_a     <= '0;
            r_iss_b     <= '0;
            r_iss_op    <= '0;
            r_last      <= 1'b1;
        end else begin
            r_iss_valid <= w_accept;
            if (w_accept) begin
                r_iss_owner <= w_sel;
                r_iss_a     <= w_sel ? req_1_a  : req_0_a;
                r_iss_b     <= w_sel ? req_1_b  : req_0_b;
                r_iss_op    <= w_sel ? req_1_op : req_0_op;
                r_last      <= w_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared ALU, evaluated on the issue register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ovf_add;
    logic                  w_ovf_sub;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_ovf;
    logic                  w_alu_cout;
    logic                  w_alu_legal;

    always_comb begin
        w_sum     = {1'b0, r_iss_a} + {1'b0, r_iss_b};
        // a - b as a + ~b + 1; carry out set means no borrow (a >= b unsigned)
        w_diff    = {1'b0, r_iss_a} + {1'b0, ~r_iss_b} + {{DATA_WIDTH{1'b0}}, 1'b1};
        w_ovf_add = (r_iss_a[c_MSB] == r_iss_b[c_MSB]) && (w_sum[c_MSB] != r_iss_a[c_MSB]);
        w_ovf_sub = (r_iss_a[c_MSB] != r_iss_b[c_MSB]) && (w_diff[c_MSB] != r_iss_a[c_MSB]);

        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        w_alu_cout   = 1'b0;
        w_alu_legal  = 1'b1;
        // Exact-value match: zero and multi-hot codes fall to default.
        case (r_iss_op)
            c_ALUOP_AND:  w_alu_result = r_iss_a & r_iss_b;
            c_ALUOP_OR:   w_alu_result = r_iss_a | r_iss_b;
            c_ALUOP_XOR:  w_alu_result = r_iss_a ^ r_iss_b;
            c_ALUOP_NOR:  w_alu_result = ~(r_iss_a | r_iss_b);
            c_ALUOP_ADD: begin
                w_alu_result = w_sum[c_MSB:0];
                w_alu_ovf    = w_ovf_add;
                w_alu_cout   = w_sum[DATA_WIDTH];
            end
            c_ALUOP_SUB: begin
                w_alu_result = w_diff[c_MSB:0];
                w_alu_ovf    = w_ovf_sub;
                w_alu_cout   = w_diff[DATA_WIDTH];
            end
            c_ALUOP_SLT: begin
                w_alu_result = {{c_MSB{1'b0}}, w_diff[c_MSB] ^ w_ovf_sub};
                w_alu_ovf    = w_ovf_sub;
                w_alu_cout   = w_diff[DATA_WIDTH];
            end
            c_ALUOP_SLTU: begin
                w_alu_result = {{c_MSB{1'b0}}, ~w_diff[DATA_WIDTH]};
                w_alu_ovf    = w_ovf_sub;
                w_alu_cout   = w_diff[DATA_WIDTH];
            end
            c_ALUOP_SLL:  w_alu_result = r_iss_a << r_iss_b[c_SHW-1:0];
            c_ALUOP_SRL:  w_alu_result = r_iss_a >> r_iss_b[c_SHW-1:0];
            c_ALUOP_SRA:  w_alu_result = $unsigned($signed(r_iss_a) >>> r_iss_b[c_SHW-1:0]);
            c_ALUOP_LUI:  w_alu_result = {r_iss_b[DATA_WIDTH/2-1:0], {(DATA_WIDTH/2){1'b0}}};
            default:      w_alu_legal  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-port response buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rsp_valid <= 2'b00;
            r_rsp_zero  <= 2'b00;
            r_rsp_ovf   <= 2'b00;
            r_rsp_cout  <= 2'b00;
            r_rsp_ill   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_rsp_result[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_iss_dst[i]) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_rsp_result[i] <= w_alu_result;
                    r_rsp_zero[i]   <= w_alu_legal && (w_alu_result == '0);
                    r_rsp_ovf[i]    <= w_alu_ovf;
                    r_rsp_cout[i]   <= w_alu_cout;
                    r_rsp_ill[i]    <= ~w_alu_legal;
                end else if (r_rsp_valid[i] && w_rsp_ready[i]) begin
                    r_rsp_valid[i]  <= 1'b0;
                end
            end
        end
    end

    assign rsp_0_valid    = r_rsp_valid[0];
    assign rsp_0_result   = r_rsp_result[0];
    assign rsp_0_zero     = r_rsp_zero[0];
    assign rsp_0_overflow = r_rsp_ovf[0];
    assign rsp_0_carryout = r_rsp_cout[0];
    assign rsp_0_illegal  = r_rsp_ill[0];
    assign rsp_1_valid    = r_rsp_valid[1];
    assign rsp_1_result   = r_rsp_result[1];
    assign rsp_1_zero     = r_rsp_zero[1];
    assign rsp_1_overflow = r_rsp_ovf[1];
    assign rsp_1_carryout = r_rsp_cout[1];
    assign rsp_1_illegal  = r_rsp_ill[1];

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. A reference model pushes
//            expected responses per port on each accepted request; a monitor
//            pops and compares on each consumed response. Directed steps
//            check timing, backpressure, illegal ops and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam logic [15:0] OP_AND  = 16'h0001;
    localparam logic [15:0] OP_OR   = 16'h0002;
    localparam logic [15:0] OP_ADD  = 16'h0004;
    localparam logic [15:0] OP_SUB  = 16'h0008;
    localparam logic [15:0] OP_SLT  = 16'h0010;
    localparam logic [15:0] OP_XOR  = 16'h0020;
    localparam logic [15:0] OP_NOR  = 16'h0040;
    localparam logic [15:0] OP_SLTU = 16'h0080;
    localparam logic [15:0] OP_SLL  = 16'h0100;
    localparam logic [15:0] OP_SRL  = 16'h0200;
    localparam logic [15:0] OP_SRA  = 16'h0400;
    localparam logic [15:0] OP_LUI  = 16'h0800;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        cout;
        logic        ill;
    } rsp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_0_valid, req_0_ready, req_1_valid, req_1_ready;
    logic [31:0] req_0_a, req_0_b, req_1_a, req_1_b;
    logic [15:0] req_0_op, req_1_op;
    logic        rsp_0_valid, rsp_0_ready, rsp_1_valid, rsp_1_ready;
    logic [31:0] rsp_0_result, rsp_1_result;
    logic        rsp_0_zero, rsp_0_overflow, rsp_0_carryout, rsp_0_illegal;
    logic        rsp_1_zero, rsp_1_overflow, rsp_1_carryout, rsp_1_illegal;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_0_valid(req_0_valid), .req_0_ready(req_0_ready),
        .req_0_a(req_0_a), .req_0_b(req_0_b), .req_0_op(req_0_op),
        .req_1_valid(req_1_valid), .req_1_ready(req_1_ready),
        .req_1_a(req_1_a), .req_1_b(req_1_b), .req_1_op(req_1_op),
        .rsp_0_valid(rsp_0_valid), .rsp_0_ready(rsp_0_ready),
        .rsp_0_result(rsp_0_result), .rsp_0_zero(rsp_0_zero),
        .rsp_0_overflow(rsp_0_overflow), .rsp_0_carryout(rsp_0_carryout),
        .rsp_0_illegal(rsp_0_illegal),
        .rsp_1_valid(rsp_1_valid), .rsp_1_ready(rsp_1_ready),
        .rsp_1_result(rsp_1_result), .rsp_1_zero(rsp_1_zero),
        .rsp_1_overflow(rsp_1_overflow), .rsp_1_carryout(rsp_1_carryout),
        .rsp_1_illegal(rsp_1_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    rsp_t q0[$], q1[$];
    rsp_t rsp0_log[$], rsp1_log[$];
    int   acc0[$], acc1[$], rsp0c[$], rsp1c[$];
    rsp_t got0, got1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the arithmetic definitions
    function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [15:0] op);
        rsp_t r;
        logic signed [63:0] sa, sb, s;
        r  = '0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        s  = sa - sb;
        case (op)
            OP_AND:  r.result = a & b;
            OP_OR:   r.result = a | b;
            OP_XOR:  r.result = a ^ b;
            OP_NOR:  r.result = ~(a | b);
            OP_ADD: begin
                r.result = a + b;
                r.cout   = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                s        = sa + sb;
                r.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB, OP_SLT, OP_SLTU: begin
                if (op == OP_SUB)      r.result = a - b;
                else if (op == OP_SLT) r.result = {31'b0, $signed(a) < $signed(b)};
                else                   r.result = {31'b0, a < b};
                r.cout = (a >= b);
                r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLL:  r.result = a << b[4:0];
            OP_SRL:  r.result = a >> b[4:0];
            OP_SRA:  r.result = $unsigned($signed(a) >>> b[4:0]);
            OP_LUI:  r.result = {b[15:0], 16'h0000};
            default: r.ill = 1'b1;
        endcase
        if (!r.ill) r.zero = (r.result == 32'h0);
        return r;
    endfunction

    // Scoreboard monitor, sampling away from the active edge
    always @(negedge clk) begin
        if (!resetn) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req_0_valid && req_0_ready) begin
                q0.push_back(model(req_0_a, req_0_b, req_0_op));
                acc0.push_back(cyc);
            end
            if (req_1_valid && req_1_ready) begin
                q1.push_back(model(req_1_a, req_1_b, req_1_op));
                acc1.push_back(cyc);
            end
            if (rsp_0_valid && rsp_0_ready) begin
                got0 = {rsp_0_result, rsp_0_zero, rsp_0_overflow, rsp_0_carryout, rsp_0_illegal};
                if (q0.size() == 0) check("rsp0_queue_nonempty", 64'(q0.size()), 64'd1);
                else                check("rsp0_scoreboard", 64'(got0), 64'(q0.pop_front()));
                rsp0_log.push_back(got0);
                rsp0c.push_back(cyc);
            end
            if (rsp_1_valid && rsp_1_ready) begin
                got1 = {rsp_1_result, rsp_1_zero, rsp_1_overflow, rsp_1_carryout, rsp_1_illegal};
                if (q1.size() == 0) check("rsp1_queue_nonempty", 64'(q1.size()), 64'd1);
                else                check("rsp1_scoreboard", 64'(got1), 64'(q1.pop_front()));
                rsp1_log.push_back(got1);
                rsp1c.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        acc0.delete(); acc1.delete(); rsp0c.delete(); rsp1c.delete();
        rsp0_log.delete(); rsp1_log.delete();
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] op);
        bit done = 1'b0;
        if (port == 0) begin
            req_0_a = a; req_0_b = b; req_0_op = op; req_0_valid = 1'b1;
        end else begin
            req_1_a = a; req_1_b = b; req_1_op = op; req_1_valid = 1'b1;
        end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = (port == 0) ? req_0_ready : req_1_ready;
        end
        check((port == 0) ? "issue0_accepted" : "issue1_accepted", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        if (port == 0) req_0_valid = 1'b0;
        else           req_1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    int   rel;
    rsp_t snap;
    bit   seen;
    int   tp[10];
    logic [31:0] ta[10], tb[10];
    logic [15:0] top[10];

    initial begin
        // ---------------- reset, requests already pending ----------------
        resetn = 1'b0;
        rsp_0_ready = 1'b1; rsp_1_ready = 1'b1;
        req_0_valid = 1'b1; req_0_a = 32'h7FFF_FFFF; req_0_b = 32'h1;         req_0_op = OP_ADD;
        req_1_valid = 1'b1; req_1_a = 32'h1234_5678; req_1_b = 32'h1234_5678; req_1_op = OP_SUB;
        step(3);
        @(negedge clk);
        check("rst_ready", 64'({req_1_ready, req_0_ready}), 64'd0);
        check("rst_rsp0", 64'({rsp_0_valid, rsp_0_result, rsp_0_zero, rsp_0_overflow,
                               rsp_0_carryout, rsp_0_illegal}), 64'd0);
        check("rst_rsp1", 64'({rsp_1_valid, rsp_1_result, rsp_1_zero, rsp_1_overflow,
                               rsp_1_carryout, rsp_1_illegal}), 64'd0);

        // ---------------- release: continuous requests on both ports ----------------
        @(posedge clk);
        #1;
        resetn = 1'b1;
        rel = cyc;
        clear_logs();
        step(5);
        req_0_valid = 1'b0; req_1_valid = 1'b0;
        step(5);
        check("tp_acc0_count", 64'(acc0.size()), 64'd2);
        check("tp_acc1_count", 64'(acc1.size()), 64'd2);
        check("tp_acc0_first", 64'(acc0[0] - rel), 64'd0);
        check("tp_acc1_first", 64'(acc1[0] - rel), 64'd1);
        check("tp_acc0_second", 64'(acc0[1] - rel), 64'd3);
        check("tp_acc1_second", 64'(acc1[1] - rel), 64'd4);
        check("tp_rsp0_first", 64'(rsp0c[0] - rel), 64'd2);
        check("tp_rsp1_first", 64'(rsp1c[0] - rel), 64'd3);
        check("tp_rsp0_second", 64'(rsp0c[1] - rel), 64'd5);
        check("tp_rsp1_second", 64'(rsp1c[1] - rel), 64'd6);
        check("add_ovf_rsp", 64'(rsp0_log[0]), 64'({32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0}));
        check("sub_eq_rsp", 64'({rsp1_log[0].result, rsp1_log[0].zero, rsp1_log[0].ovf}),
              64'({32'h0, 1'b1, 1'b0}));

        // ---------------- op mix across both ports ----------------
        clear_logs();
        tp = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 1};
        ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000,
               32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'hF0F0_F0F0, 32'hA000_000A};
        tb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_001F, 32'h0000_0004,
               32'h0000_0004, 32'h0000_ABCD, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0500_0050};
        top = '{OP_SLT, OP_ADD, OP_SUB, OP_SLL, OP_SRA, OP_SRL, OP_LUI, OP_SLTU, OP_NOR, OP_OR};
        for (int i = 0; i < 10; i++) issue(tp[i], ta[i], tb[i], top[i]);
        step(5);
        check("mix_rsp0_count", 64'(rsp0_log.size()), 64'd5);
        check("mix_rsp1_count", 64'(rsp1_log.size()), 64'd5);
        check("slt_neg_result", 64'(rsp1_log[0].result), 64'd1);
        check("add_carry_rsp", 64'(rsp0_log[0]), 64'({32'h0, 1'b1, 1'b0, 1'b1, 1'b0}));
        check("sra_result", 64'(rsp0_log[2].result), 64'hF800_0000);

        // ---------------- illegal ops then a legal AND ----------------
        clear_logs();
        issue(0, 32'h1234_5678, 32'h0F0F_FFFF, 16'h0003);
        issue(0, 32'h1234_5678, 32'h0F0F_FFFF, 16'h0000);
        issue(0, 32'h1234_5678, 32'h0F0F_FFFF, 16'h1000);
        issue(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND);
        step(4);
        check("ill_count", 64'(rsp0_log.size()), 64'd4);
        for (int k = 0; k < 3; k++)
            check("ill_rsp", 64'(rsp0_log[k]), 64'({32'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        check("and_after_ill", 64'({rsp0_log[3].result, rsp0_log[3].ill}),
              64'({32'h00F0_00F0, 1'b0}));

        // ---------------- backpressure on port 0 ----------------
        clear_logs();
        rsp_0_ready = 1'b0;
        issue(0, 32'hA5A5_A5A5, 32'hFFFF_0000, OP_XOR);
        req_0_a = 32'h0000_1111; req_0_b = 32'h2222_0000; req_0_op = OP_OR;  req_0_valid = 1'b1;
        req_1_a = 32'h8000_0000; req_1_b = 32'h0000_0004; req_1_op = OP_SRA; req_1_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = rsp_0_valid;
        end
        check("bp_rsp0_valid", 64'(seen), 64'd1);
        snap = {rsp_0_result, rsp_0_zero, rsp_0_overflow, rsp_0_carryout, rsp_0_illegal};
        check("bp_xor_value", 64'(snap.result), 64'h5A5A_A5A5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold", 64'({rsp_0_valid, rsp_0_result, rsp_0_zero, rsp_0_overflow,
                                  rsp_0_carryout, rsp_0_illegal}), 64'({1'b1, snap}));
            check("bp_req0_ready_low", 64'(req_0_ready), 64'd0);
        end
        check("bp_p1_count", 64'(rsp1c.size()), 64'd2);
        check("bp_p1_spacing", 64'(rsp1c[1] - rsp1c[0]), 64'd3);
        @(posedge clk);
        #1;
        rsp_0_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = req_0_ready;
        end
        check("bp_req0_regrant", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        req_0_valid = 1'b0; req_1_valid = 1'b0;
        step(6);
        check("bp_rsp0_count", 64'(rsp0_log.size()), 64'd2);
        check("bp_rsp0_first", 64'(rsp0_log[0]), 64'(snap));

        // ---------------- reset mid-flight ----------------
        issue(0, 32'h1111_1111, 32'h2222_2222, OP_ADD);
        resetn = 1'b0;
        req_0_a = 32'd3;  req_0_b = 32'd4; req_0_op = OP_ADD; req_0_valid = 1'b1;
        req_1_a = 32'd10; req_1_b = 32'd3; req_1_op = OP_SUB; req_1_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("mid_rst_rsp0_low", 64'(rsp_0_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        rel = cyc;
        clear_logs();
        @(negedge clk);
        check("rel_rsp0_low", 64'(rsp_0_valid), 64'd0);
        step(1);
        step(1);
        req_0_valid = 1'b0; req_1_valid = 1'b0;
        step(5);
        check("rel_acc0_first", 64'(acc0[0] - rel), 64'd0);
        check("rel_acc1_first", 64'(acc1[0] - rel), 64'd1);
        check("rel_rsp0_count", 64'(rsp0_log.size()), 64'd1);
        check("rel_rsp0_result", 64'(rsp0_log[0].result), 64'd7);
        check("rel_rsp1_result", 64'(rsp1_log[0].result), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
